// File: rtl/serial_sub_ctrl.sv
// ---------------------------------------------------------------------------
// serial_sub_ctrl
//
// Bit-serial WIDTH-bit subtractor controller. One combinational 1-bit NAND
// full-subtractor cell (fs_nand) is time-shared across all operand bits,
// LSB first, one bit per clock. Operands are captured on an accepted start.
// The borrow is chained through a single flop. The assembled result is
// presented together with a one-cycle done pulse.
//
// Optional feature macro: SERIAL_SUB_SIGNED_EN
//   When defined, adds output ovf: a registered two's-complement overflow
//   flag that is held with diff.
//
// Ports:
//   clk     in   1      system clock, rising edge
//   rst_n   in   1      asynchronous active-low reset
//   start   in   1      request, sampled only in IDLE or DONE
//   a       in   WIDTH  minuend, captured on accepted start
//   b       in   WIDTH  subtrahend, captured on accepted start
//   bin_in  in   1      initial borrow, captured on accepted start
//   busy    out  1      high while the serial operation runs
//   done    out  1      one-cycle pulse, result valid
//   diff    out  WIDTH  a-b-bin_in mod 2^WIDTH, held until next start
//   bout    out  1      final borrow out, held with diff
//   ovf     out  1      (SERIAL_SUB_SIGNED_EN only) signed overflow
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// fs_nand
//
// 1-bit full subtractor built only from 2-input NAND terms.
//   diff = a ^ b ^ bin
//   bout = ~a & b | ~(a ^ b) & bin
//
// Ports:
//   a, b, bin  in   1  minuend bit, subtrahend bit, borrow in
//   diff       out  1  difference bit
//   bout       out  1  borrow out
// ---------------------------------------------------------------------------
module fs_nand (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);

   logic t1;
   logic axb;
   logic t2;
   logic na;
   logic nx;
   logic p;
   logic q;

   // First XOR stage (a ^ b) from four NANDs.
   assign t1  = ~(a & b);
   assign axb = ~(~(a & t1) & ~(b & t1));

   // Second XOR stage folds in the borrow to form the difference bit.
   assign t2   = ~(axb & bin);
   assign diff = ~(~(axb & t2) & ~(bin & t2));

   // Borrow out as a NAND-NAND sum of products: ~a&b | ~(a^b)&bin.
   // The inverters are NANDs with tied inputs.
   assign na   = ~(a & a);
   assign nx   = ~(axb & axb);
   assign p    = ~(na & b);
   assign q    = ~(nx & bin);
   assign bout = ~(p & q);

endmodule

module serial_sub_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SERIAL_SUB_SIGNED_EN
   ,
   output logic             ovf
`endif
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             load;
   logic             shift;
   logic             last;

   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic             brw;
   logic [WIDTH-2:0] res;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] diff_q;
   logic             bout_q;

   logic             cell_diff;
   logic             cell_bout;
   logic [WIDTH-1:0] res_next;

`ifdef SERIAL_SUB_SIGNED_EN
   logic             a_msb;
   logic             b_msb;
   logic             ovf_q;
`endif

   // The single shared subtractor cell always looks at the current LSBs of
   // the operand shift registers and the chained borrow flop.
   fs_nand u_cell (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .bin  (brw),
      .diff (cell_diff),
      .bout (cell_bout)
   );

   // The newest difference bit enters at the top. The lower WIDTH-1 bits
   // are already-computed bits, so on the final RUN edge this vector is
   // the complete result.
   assign res_next = {cell_diff, res};

   // State register. Reset drops straight back to IDLE, aborting any
   // operation in flight without a done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and datapath strobes. A start is honoured in IDLE
   // and in DONE; accepting it in DONE gives back-to-back operation with
   // no idle gap. RUN ignores start and leaves after exactly WIDTH edges.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      shift     = 1'b0;
      last      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            shift = 1'b1;
            if (cnt == CNT_LAST) begin
               last      = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Serial datapath. A load captures the operands and the initial borrow.
   // Each RUN edge consumes one operand bit pair, shifts the difference
   // bit into the result register and updates the borrow. The counter
   // stops at WIDTH-1 on the final edge instead of wrapping. On that same
   // edge the complete result and final borrow are latched into the output
   // registers, which hold until a later operation completes or a reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         brw    <= 1'b0;
         res    <= '0;
         cnt    <= '0;
         diff_q <= '0;
         bout_q <= 1'b0;
      end else if (load) begin
         a_sr <= a;
         b_sr <= b;
         brw  <= bin_in;
         cnt  <= '0;
      end else if (shift) begin
         a_sr <= a_sr >> 1;
         b_sr <= b_sr >> 1;
         brw  <= cell_bout;
         res  <= res_next[WIDTH-1:1];
         if (last) begin
            diff_q <= res_next;
            bout_q <= cell_bout;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

`ifdef SERIAL_SUB_SIGNED_EN
   // Signed overflow. The operand MSBs are kept at load time because the
   // shift registers have consumed them by the end of the run. The flag
   // is formed from those MSBs and the final result bit, and is registered
   // together with diff.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         ovf_q <= 1'b0;
      end else if (load) begin
         a_msb <= a[WIDTH-1];
         b_msb <= b[WIDTH-1];
      end else if (last) begin
         ovf_q <= (a_msb != b_msb) && (cell_diff != a_msb);
      end
   end

   assign ovf = ovf_q;
`endif

   // Status and result outputs come directly from state and registers.
   assign busy = (state == RUN);
   assign done = (state == DONE);
   assign diff = diff_q;
   assign bout = bout_q;

endmodule
